// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART link constants and receiver state encoding
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 16;
    localparam int DEFAULT_DATA_BITS    = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer for the serial line, resets to idle-high
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic bit_in,
    output logic rx_s
);

    logic sync1;
    logic sync2;

    // Two-stage capture of the asynchronous line; reset to 1 so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= bit_in;
            sync2 <= sync1;
        end
    end

    assign rx_s = sync2;

endmodule

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with glitch rejection and framing error pulse
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bit_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

    logic                 rx_s;

    rx_state_t            state_q,   state_n;
    logic [CNT_W-1:0]     cnt_q,     cnt_n;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_n;
    logic [DATA_BITS-1:0] shift_q,   shift_n;
    logic [DATA_BITS-1:0] data_q,    data_n;
    logic                 valid_q,   valid_n;
    logic                 ferr_q,    ferr_n;

    uart_rx_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .bit_in (bit_in),
        .rx_s   (rx_s)
    );

    // State, counters, shift register and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_n;
            cnt_q     <= cnt_n;
            bit_idx_q <= bit_idx_n;
            shift_q   <= shift_n;
            data_q    <= data_n;
            valid_q   <= valid_n;
            ferr_q    <= ferr_n;
        end
    end

    // Frame sequencing: the start bit is checked at its midpoint, so every later
    // sample taken one full bit period apart also lands mid-bit
    always_comb begin
        state_n   = state_q;
        cnt_n     = cnt_q;
        bit_idx_n = bit_idx_q;
        shift_n   = shift_q;
        data_n    = data_q;
        valid_n   = 1'b0;
        ferr_n    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = START;
                end
            end

            START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n   = DATA;
                        bit_idx_n = '0;
                    end else begin
                        // Line went high again before mid-start: treat as a glitch
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end

            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_n     = '0;
                    shift_n   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_idx_n = bit_idx_q + 1'b1;
                    if (bit_idx_q == IDX_LAST) begin
                        state_n = STOP;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end

            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shift_q;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = RECOVER;
                    end
                end else begin
                    cnt_n = cnt_q + 1'b1;
                end
            end

            RECOVER: begin
                // A held-low line (break) must return high before a new frame can start
                cnt_n = '0;
                if (rx_s) begin
                    state_n = IDLE;
                end
            end

            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    assign data_out    = data_q;
    assign valid       = valid_q;
    assign frame_error = ferr_q;
    assign busy        = (state_q != IDLE);

endmodule
